// File: rtl/result_image_writer_pkg.sv
// Shared image geometry, widths and FSM encoding for the result image writer.
package result_image_writer_pkg;

    localparam int IMG_W        = 100;
    localparam int IMG_H        = 100;
    localparam int PIX_W        = 8;
    localparam int ADDR_W       = 14;
    localparam int BCNT_W       = 10;
    localparam int INTERIOR_PIX = (IMG_W - 2) * (IMG_H - 2);
    localparam int BORDER_PIX   = 2 * IMG_W + 2 * (IMG_H - 2);

    localparam logic [0:0] ST_ACTIVE = 1'b0;
    localparam logic [0:0] ST_DONE   = 1'b1;

    // Compile-time address constants only; the datapath never multiplies.
    function automatic logic [ADDR_W-1:0] pix_addr(input int row, input int col);
        return ADDR_W'(row * IMG_W + col);
    endfunction

endpackage

// File: rtl/result_image_writer_if.sv
// Pixel input stream, BRAM write port and status flags of the result image writer.
interface result_image_writer_if;
    import result_image_writer_pkg::*;

    logic              start;
    logic              in_valid;
    logic [PIX_W-1:0]  in_pixel;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [PIX_W-1:0]  wr_data;
    logic [ADDR_W-1:0] pixel_count;
    logic              frame_done;
    logic              overflow_err;

    modport master (
        output start, in_valid, in_pixel,
        input  wr_en, wr_addr, wr_data, pixel_count, frame_done, overflow_err
    );

    modport slave (
        input  start, in_valid, in_pixel,
        output wr_en, wr_addr, wr_data, pixel_count, frame_done, overflow_err
    );

endinterface

// File: rtl/result_image_writer_border_addr_gen.sv
// Walks the image border (top row, bottom row, left column, right column) one address per advance.
module result_image_writer_border_addr_gen
    import result_image_writer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_i,
    input  logic              advance_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              done_o
);

    localparam logic [BCNT_W-1:0] SEG1_CNT = BCNT_W'(IMG_W);
    localparam logic [BCNT_W-1:0] SEG2_CNT = BCNT_W'(2 * IMG_W);
    localparam logic [BCNT_W-1:0] SEG3_CNT = BCNT_W'(2 * IMG_W + IMG_H - 2);
    localparam logic [BCNT_W-1:0] END_CNT  = BCNT_W'(BORDER_PIX);
    localparam logic [ADDR_W-1:0] SEG1_ADDR = pix_addr(IMG_H - 1, 0);
    localparam logic [ADDR_W-1:0] SEG2_ADDR = pix_addr(1, 0);
    localparam logic [ADDR_W-1:0] SEG3_ADDR = pix_addr(1, IMG_W - 1);
    localparam logic [ADDR_W-1:0] COL_STEP  = ADDR_W'(IMG_W);

    logic [BCNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [ADDR_W-1:0] addr_q, addr_d;

    // Rows step by +1, columns by +IMG_W; segment starts are loaded as constants.
    always_comb begin
        cnt_inc = cnt_q + BCNT_W'(1);
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        if (clear_i) begin
            cnt_d  = '0;
            addr_d = '0;
        end else if (advance_i && !done_o) begin
            cnt_d = cnt_inc;
            if (cnt_inc == SEG1_CNT)      addr_d = SEG1_ADDR;
            else if (cnt_inc == SEG2_CNT) addr_d = SEG2_ADDR;
            else if (cnt_inc == SEG3_CNT) addr_d = SEG3_ADDR;
            else if (cnt_inc < SEG2_CNT)  addr_d = addr_q + ADDR_W'(1);
            else                          addr_d = addr_q + COL_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            addr_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            addr_q <= addr_d;
        end
    end

    assign addr_o = addr_q;
    assign done_o = (cnt_q == END_CNT);

endmodule

// File: rtl/result_image_writer.sv
// Stores filtered interior pixels into the output image BRAM, fills the border in idle cycles.
module result_image_writer
    import result_image_writer_pkg::*;
#(
    parameter logic [PIX_W-1:0] BORDER_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    result_image_writer_if.slave  io
);

    localparam logic [ADDR_W-1:0] INT_START = pix_addr(1, 1);
    localparam logic [ADDR_W-1:0] FIRST_COL = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_COL  = ADDR_W'(IMG_W - 2);
    localparam logic [ADDR_W-1:0] ROW_SKIP  = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] INT_TOTAL = ADDR_W'(INTERIOR_PIX);

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] int_addr_q, int_addr_d;
    logic [ADDR_W-1:0] col_q, col_d;
    logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [PIX_W-1:0]  wr_data_q, wr_data_d;
    logic              ovf_q, ovf_d;
    logic [ADDR_W-1:0] bord_addr;
    logic              bord_done, bord_adv, bord_clr, int_full;

    assign int_full = (pix_cnt_q == INT_TOTAL);

    result_image_writer_border_addr_gen u_border (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (bord_clr),
        .advance_i (bord_adv),
        .addr_o    (bord_addr),
        .done_o    (bord_done)
    );

    always_comb begin
        state_d    = state_q;
        int_addr_d = int_addr_q;
        col_d      = col_q;
        pix_cnt_d  = pix_cnt_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        ovf_d      = ovf_q;
        bord_adv   = 1'b0;
        bord_clr   = 1'b0;
        if (state_q == ST_ACTIVE) begin
            if (int_full && bord_done) state_d = ST_DONE;
            // Interior pixels always win the single write port; the border only uses idle slots.
            if (io.in_valid && !int_full) begin
                wr_en_d   = 1'b1;
                wr_addr_d = int_addr_q;
                wr_data_d = io.in_pixel;
                pix_cnt_d = pix_cnt_q + ADDR_W'(1);
                if (col_q == LAST_COL) begin
                    int_addr_d = int_addr_q + ROW_SKIP;
                    col_d      = FIRST_COL;
                end else begin
                    int_addr_d = int_addr_q + ADDR_W'(1);
                    col_d      = col_q + ADDR_W'(1);
                end
            end else begin
                if (io.in_valid) ovf_d = 1'b1;
                if (!bord_done) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = bord_addr;
                    wr_data_d = BORDER_VAL;
                    bord_adv  = 1'b1;
                end
            end
        end else begin
            if (io.in_valid) ovf_d = 1'b1;
            if (io.start) begin
                state_d    = ST_ACTIVE;
                int_addr_d = INT_START;
                col_d      = FIRST_COL;
                pix_cnt_d  = '0;
                bord_clr   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_ACTIVE;
            int_addr_q <= INT_START;
            col_q      <= FIRST_COL;
            pix_cnt_q  <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            int_addr_q <= int_addr_d;
            col_q      <= col_d;
            pix_cnt_q  <= pix_cnt_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            ovf_q      <= ovf_d;
        end
    end

    assign io.wr_en        = wr_en_q;
    assign io.wr_addr      = wr_addr_q;
    assign io.wr_data      = wr_data_q;
    assign io.pixel_count  = pix_cnt_q;
    assign io.frame_done   = (state_q == ST_DONE);
    assign io.overflow_err = ovf_q;

endmodule

// File: tb/tb_result_image_writer.sv
// Bench for result_image_writer: full frames checked against an image-level reference model.
module tb_result_image_writer;
    import result_image_writer_pkg::*;

    localparam int NPIX  = INTERIOR_PIX;
    localparam int NADDR = IMG_W * IMG_H;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    result_image_writer_if io();
    result_image_writer dut (.clk(clk), .rst(rst), .io(io));

    int n_chk = 0;
    int n_fail = 0;
    int cyc_n = 0;
    int wcnt [NADDR];
    logic [7:0] mem [NADDR];
    int n_wr, last_wr_cyc, done_rise_cyc;
    logic prev_done;
    logic [7:0] exp_data [NPIX];
    logic       obs_en   [NPIX];
    int         obs_addr [NPIX];
    logic [7:0] obs_data [NPIX];

    typedef struct { int n; int addr; int data; } vec_t;
    vec_t tbl [4];

    // Reference: k-th interior pixel in raster order over rows/cols 1..IMG-2.
    function automatic int interior_addr(input int k);
        return (k / (IMG_W - 2) + 1) * IMG_W + (k % (IMG_W - 2)) + 1;
    endfunction

    function automatic bit is_border(input int a);
        int r, c;
        r = a / IMG_W;
        c = a % IMG_W;
        return (r == 0) || (r == IMG_H - 1) || (c == 0) || (c == IMG_W - 1);
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        cyc_n++;
        if (io.wr_en === 1'b1) begin
            if (int'(io.wr_addr) < NADDR) begin
                wcnt[io.wr_addr]++;
                mem[io.wr_addr] = io.wr_data;
            end
            n_wr++;
            last_wr_cyc = cyc_n;
        end
        if (io.frame_done === 1'b1 && !prev_done) done_rise_cyc = cyc_n;
        prev_done = (io.frame_done === 1'b1);
    endtask

    task automatic clear_log();
        for (int a = 0; a < NADDR; a++) begin
            wcnt[a] = 0;
            mem[a]  = 8'hEE;
        end
        n_wr = 0;
        last_wr_cyc = -1;
        done_rise_cyc = -1;
        prev_done = (io.frame_done === 1'b1);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_wr_en"}, io.wr_en, 0);
        chk({tag, "_wr_addr"}, io.wr_addr, 0);
        chk({tag, "_wr_data"}, io.wr_data, 0);
        chk({tag, "_pixel_count"}, io.pixel_count, 0);
        chk({tag, "_frame_done"}, io.frame_done, 0);
        chk({tag, "_overflow_err"}, io.overflow_err, 0);
    endtask

    // mode 0: data n mod 256, 3 idle cycles; mode 1: random back-to-back; mode 2: random gaps.
    task automatic run_frame(input int mode);
        logic [7:0] d;
        int gap, k;
        for (int n = 0; n < NPIX; n++) begin
            d = (mode == 0) ? 8'(n) : 8'($urandom_range(0, 255));
            exp_data[n] = d;
            io.in_valid = 1'b1;
            io.in_pixel = d;
            cyc();
            io.in_valid = 1'b0;
            obs_en[n]   = io.wr_en;
            obs_addr[n] = int'(io.wr_addr);
            obs_data[n] = io.wr_data;
            gap = (mode == 0) ? 3 : (mode == 1) ? 0 : int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                if (mode == 0 && n == 5000 && g == 0) io.start = 1'b1;
                cyc();
                if (io.start) begin
                    io.start = 1'b0;
                    chk("start_midframe_count", io.pixel_count, 5001);
                end
            end
        end
        k = 0;
        while (io.frame_done !== 1'b1 && k < 2000) begin
            cyc();
            k++;
        end
    endtask

    task automatic verify_frame(input string tag);
        int bad_lat, bad_once, bad_val;
        logic [7:0] exp_img [NADDR];
        bad_lat = 0; bad_once = 0; bad_val = 0;
        for (int a = 0; a < NADDR; a++) exp_img[a] = 8'h00;
        for (int n = 0; n < NPIX; n++) begin
            exp_img[interior_addr(n)] = exp_data[n];
            if (obs_en[n] !== 1'b1 || obs_addr[n] != interior_addr(n) || obs_data[n] !== exp_data[n])
                bad_lat++;
        end
        for (int a = 0; a < NADDR; a++) begin
            if (wcnt[a] != 1) bad_once++;
            if (mem[a] !== exp_img[a] || (is_border(a) && mem[a] !== 8'h00)) bad_val++;
        end
        chk({tag, "_frame_done"}, io.frame_done, 1);
        chk({tag, "_pixel_count"}, io.pixel_count, NPIX);
        chk({tag, "_interior_write_errs"}, bad_lat, 0);
        chk({tag, "_wr_pulses"}, n_wr, NADDR);
        chk({tag, "_addr_not_once"}, bad_once, 0);
        chk({tag, "_image_errs"}, bad_val, 0);
        chk({tag, "_done_rise_cycle"}, done_rise_cyc, last_wr_cyc + 1);
    endtask

    initial begin
        tbl[0] = '{n: 0,    addr: 101,  data: 8'h00};
        tbl[1] = '{n: 97,   addr: 198,  data: 8'h61};
        tbl[2] = '{n: 98,   addr: 201,  data: 8'h62};
        tbl[3] = '{n: 9603, addr: 9898, data: 8'h83};

        io.start = 1'b0;
        io.in_valid = 1'b0;
        io.in_pixel = '0;
        rst = 1'b1;
        clear_log();
        repeat (3) cyc();
        check_zero_outputs("reset");

        rst = 1'b0;
        clear_log();
        run_frame(0);
        verify_frame("frame1");
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("vec%0d_addr", i), obs_addr[tbl[i].n], tbl[i].addr);
            chk($sformatf("vec%0d_data", i), obs_data[tbl[i].n], tbl[i].data);
        end

        io.in_valid = 1'b1;
        io.in_pixel = 8'hAA;
        cyc();
        io.in_valid = 1'b0;
        chk("ovf_no_write", io.wr_en, 0);
        chk("ovf_flag", io.overflow_err, 1);
        chk("ovf_still_done", io.frame_done, 1);
        io.start = 1'b1;
        cyc();
        io.start = 1'b0;
        chk("start_clears_done", io.frame_done, 0);
        chk("ovf_sticky_after_start", io.overflow_err, 1);
        chk("start_clears_count", io.pixel_count, 0);

        rst = 1'b1;
        cyc();
        rst = 1'b0;
        clear_log();
        run_frame(1);
        verify_frame("b2b");

        clear_log();
        io.start = 1'b1;
        io.in_valid = 1'b1;
        io.in_pixel = 8'h3C;
        cyc();
        io.start = 1'b0;
        io.in_valid = 1'b0;
        chk("start_pix_no_write", io.wr_en, 0);
        chk("start_pix_done_low", io.frame_done, 0);
        chk("start_pix_ovf", io.overflow_err, 1);
        chk("start_pix_count", io.pixel_count, 0);
        clear_log();
        run_frame(2);
        verify_frame("frame3");

        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int n = 0; n < 500; n++) begin
            io.in_valid = 1'b1;
            io.in_pixel = 8'($urandom_range(0, 255));
            cyc();
        end
        io.in_valid = 1'b0;
        chk("midframe_count", io.pixel_count, 500);
        rst = 1'b1;
        cyc();
        check_zero_outputs("midrst");
        rst = 1'b0;
        io.in_valid = 1'b1;
        io.in_pixel = 8'h5C;
        cyc();
        io.in_valid = 1'b0;
        chk("post_rst_pix_en", io.wr_en, 1);
        chk("post_rst_pix_addr", io.wr_addr, 101);
        chk("post_rst_pix_data", io.wr_data, 8'h5C);
        cyc();
        chk("post_rst_border_en", io.wr_en, 1);
        chk("post_rst_border_addr", io.wr_addr, 0);
        chk("post_rst_border_data", io.wr_data, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
